// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clock_pkg : shared state encoding, buzzer timing constants, defaults |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2,
    ST_CHIME  = 2'd3
  } buz_state_e;

  localparam int unsigned C_PHASE_W      = 9;
  localparam logic [8:0]  C_RING_ON_MS   = 9'd250;
  localparam logic [8:0]  C_RING_OFF_MS  = 9'd250;
  localparam logic [8:0]  C_CHIME_ON_MS  = 9'd200;
  localparam logic [8:0]  C_CHIME_OFF_MS = 9'd300;

  localparam int C_RING_SECS_DEF   = 10;
  localparam int C_SNOOZE_SECS_DEF = 60;
  localparam int C_MAX_SNOOZE_DEF  = 3;

  // Hourly beep count on a 12-hour dial: midnight and noon give 12.
  function automatic logic [3:0] chime_beeps(input logic [4:0] hours);
    logic [4:0] m;
    m = hours % 5'd12;
    return (m == 5'd0) ? 4'd12 : m[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/buzzer_sched_beep_pattern.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | beep_pattern : restartable 0..499 ms phase counter with on/off level |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module beep_pattern
  import clock_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic chime_sel,
  output logic phase_last,
  output logic level_next
);

  logic [C_PHASE_W-1:0] phase_q, phase_d;
  logic [C_PHASE_W-1:0] period_last;
  logic [C_PHASE_W-1:0] on_ms;
  logic                 sel_q, sel_d;

  always_comb begin
    sel_d       = chime_sel;
    period_last = sel_q ? (C_CHIME_ON_MS + C_CHIME_OFF_MS - 9'd1)
                        : (C_RING_ON_MS + C_RING_OFF_MS - 9'd1);
    phase_last  = (phase_q >= period_last);
    if (restart || phase_last) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 9'd1;
    end
    // Level reflects the phase about to be registered so the top can flop it.
    on_ms      = chime_sel ? C_CHIME_ON_MS : C_RING_ON_MS;
    level_next = (phase_d < on_ms);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sel_q   <= sel_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/buzzer_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | buzzer_sched : alarm ring / snooze / hourly chime buzzer scheduler   |
// | Optional hourly chime enabled by macro BUZZER_CHIME_EN.              |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module buzzer_sched
  import clock_pkg::*;
#(
  parameter int RING_SECS   = C_RING_SECS_DEF,
  parameter int SNOOZE_SECS = C_SNOOZE_SECS_DEF,
  parameter int MAX_SNOOZE  = C_MAX_SNOOZE_DEF
) (
  input  logic       CP_1KHz,
  input  logic       CR,
  input  logic       tick_1hz,
  input  logic       alarm_match,
  input  logic       chime_match,
  input  logic [4:0] hours_24,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       alarm_led,
  output logic [1:0] snooze_left,
  output logic [1:0] state
);

  localparam int RING_W = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam int SNZ_W  = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
  localparam logic [RING_W-1:0] RING_LAST   = RING_W'(RING_SECS - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST    = SNZ_W'(SNOOZE_SECS - 1);
  localparam logic [1:0]        SNOOZE_LOAD = 2'(MAX_SNOOZE);

  buz_state_e        state_q, state_d;
  logic [1:0]        snooze_left_q, snooze_left_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic              snz_prev_q, snz_prev_d;
  logic              stop_prev_q, stop_prev_d;
  logic              buzzer_q, buzzer_d;
  logic              alarm_led_q, alarm_led_d;
  logic              snooze_edge, stop_edge;
  logic              pat_restart, pat_chime, phase_last, level_next;

`ifdef BUZZER_CHIME_EN
  logic [3:0] beep_n_q, beep_n_d;
  logic [3:0] beep_idx_q, beep_idx_d;
`else
  logic unused_chime_in;
  assign unused_chime_in = chime_match ^ (^hours_24) ^ phase_last;
`endif

  assign snz_prev_d  = snooze_btn;
  assign stop_prev_d = stop_btn;
  assign snooze_edge = snooze_btn & ~snz_prev_q;
  assign stop_edge   = stop_btn & ~stop_prev_q;

  always_comb begin
    state_d       = state_q;
    snooze_left_d = snooze_left_q;
    ring_cnt_d    = ring_cnt_q;
    snz_cnt_d     = snz_cnt_q;
`ifdef BUZZER_CHIME_EN
    beep_n_d      = beep_n_q;
    beep_idx_d    = beep_idx_q;
`endif
    if (alarm_match) begin
      state_d    = ST_RING;
      ring_cnt_d = '0;
      if (state_q == ST_IDLE || state_q == ST_CHIME) begin
        snooze_left_d = SNOOZE_LOAD;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef BUZZER_CHIME_EN
          if (chime_match) begin
            state_d    = ST_CHIME;
            beep_n_d   = chime_beeps(hours_24);
            beep_idx_d = 4'd1;
          end
`endif
        end
        ST_RING: begin
          if (stop_edge || (snooze_edge && snooze_left_q == 2'd0)) begin
            state_d = ST_IDLE;
          end else if (snooze_edge) begin
            state_d       = ST_SNOOZE;
            snooze_left_d = snooze_left_q - 2'd1;
            snz_cnt_d     = '0;
          end else if (tick_1hz) begin
            if (ring_cnt_q >= RING_LAST) begin
              state_d = ST_IDLE;
            end else begin
              ring_cnt_d = ring_cnt_q + 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop_edge) begin
            state_d = ST_IDLE;
          end else if (tick_1hz) begin
            if (snz_cnt_q >= SNZ_LAST) begin
              state_d    = ST_RING;
              ring_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q + 1'b1;
            end
          end
        end
        default: begin
`ifdef BUZZER_CHIME_EN
          // A beep slot ends at the phase wrap; the last slot returns to idle.
          if (phase_last) begin
            if (beep_idx_q >= beep_n_q) begin
              state_d = ST_IDLE;
            end else begin
              beep_idx_d = beep_idx_q + 4'd1;
            end
          end
`else
          state_d = ST_IDLE;
`endif
        end
      endcase
    end
  end

  assign pat_restart = alarm_match || (state_d != state_q) ||
                       !(state_q == ST_RING || state_q == ST_CHIME);
  assign pat_chime   = (state_d == ST_CHIME);

  beep_pattern u_beep_pattern (
    .clk        (CP_1KHz),
    .rst        (CR),
    .restart    (pat_restart),
    .chime_sel  (pat_chime),
    .phase_last (phase_last),
    .level_next (level_next)
  );

  always_comb begin
    buzzer_d    = (state_d == ST_RING || state_d == ST_CHIME) && level_next;
    alarm_led_d = (state_d == ST_RING);
  end

  always_ff @(posedge CP_1KHz) begin
    if (CR) begin
      state_q       <= ST_IDLE;
      snooze_left_q <= 2'd0;
      ring_cnt_q    <= '0;
      snz_cnt_q     <= '0;
      snz_prev_q    <= 1'b0;
      stop_prev_q   <= 1'b0;
      buzzer_q      <= 1'b0;
      alarm_led_q   <= 1'b0;
`ifdef BUZZER_CHIME_EN
      beep_n_q      <= 4'd0;
      beep_idx_q    <= 4'd0;
`endif
    end else begin
      state_q       <= state_d;
      snooze_left_q <= snooze_left_d;
      ring_cnt_q    <= ring_cnt_d;
      snz_cnt_q     <= snz_cnt_d;
      snz_prev_q    <= snz_prev_d;
      stop_prev_q   <= stop_prev_d;
      buzzer_q      <= buzzer_d;
      alarm_led_q   <= alarm_led_d;
`ifdef BUZZER_CHIME_EN
      beep_n_q      <= beep_n_d;
      beep_idx_q    <= beep_idx_d;
`endif
    end
  end

  assign buzzer      = buzzer_q;
  assign alarm_led   = alarm_led_q;
  assign snooze_left = snooze_left_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_buzzer_sched : self-checking bench for buzzer_sched               |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_buzzer_sched;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RING   = 2'd1;
  localparam logic [1:0] S_SNOOZE = 2'd2;
  localparam logic [1:0] S_CHIME  = 2'd3;
  localparam int NV = 20;

  logic       clk = 1'b0;
  logic       cr = 1'b1, tick = 1'b0, alarm = 1'b0, chime = 1'b0;
  logic       snz = 1'b0, stp = 1'b0;
  logic [4:0] hrs = 5'd0;
  logic       buzzer, alarm_led;
  logic [1:0] snooze_left, state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       bz;
    logic       led;
    logic [1:0] sl;
    bit         chk_bz;
  } exp_t;

  typedef struct {
    string      name;
    bit         alarm;
    bit         chime;
    bit         snz;
    bit         stp;
    logic [1:0] st;
    logic       bz;
    logic       led;
    logic [1:0] sl;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[NV];

  buzzer_sched dut (
    .CP_1KHz     (clk),
    .CR          (cr),
    .tick_1hz    (tick),
    .alarm_match (alarm),
    .chime_match (chime),
    .hours_24    (hrs),
    .snooze_btn  (snz),
    .stop_btn    (stp),
    .buzzer      (buzzer),
    .alarm_led   (alarm_led),
    .snooze_left (snooze_left),
    .state       (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, bit a, bit c, bit s, bit p,
                              logic [1:0] st, logic bz, logic led, logic [1:0] sl);
    vec_t v;
    v.name = n; v.alarm = a; v.chime = c; v.snz = s; v.stp = p;
    v.st = st; v.bz = bz; v.led = led; v.sl = sl;
    return v;
  endfunction

  task automatic expect_out(string name, logic [1:0] st, logic bz, logic led,
                            logic [1:0] sl, bit chk_bz);
    exp_t e;
    e.name = name; e.st = st; e.bz = bz; e.led = led; e.sl = sl; e.chk_bz = chk_bz;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got no expectation, want one queued");
      return;
    end
    e = sb.pop_front();
    if (state !== e.st || alarm_led !== e.led || snooze_left !== e.sl ||
        (e.chk_bz && buzzer !== e.bz)) begin
      bad++;
      $display("FAIL %s: got st=%0d bz=%0d led=%0d sl=%0d, want st=%0d bz=%0d led=%0d sl=%0d",
               e.name, state, buzzer, alarm_led, snooze_left, e.st, e.bz, e.led, e.sl);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(bit chk);
    @(posedge clk);
    #1;
    if (chk) check_pop();
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0);
  endtask

  task automatic pulse_ticks(int n);
    repeat (n) begin
      tick = 1'b1; cyc(1'b0);
      tick = 1'b0; cyc(1'b0);
    end
  endtask

  task automatic do_reset();
    cr = 1'b1; alarm = 1'b0; chime = 1'b0; tick = 1'b0; snz = 1'b0; stp = 1'b0;
    cyc(1'b0); cyc(1'b0);
    cr = 1'b0;
  endtask

  task automatic count_highs(int n, output int highs, output int not_idle);
    highs = 0; not_idle = 0;
    repeat (n) begin
      cyc(1'b0);
      if (buzzer !== 1'b0) highs++;
      if (state !== S_IDLE) not_idle++;
    end
  endtask

`ifdef BUZZER_CHIME_EN
  // Count beeps and check each on-time until the chime returns to idle.
  task automatic watch_chime(string name, int exp_beeps);
    int beeps = 0, run = 0, bad_len = 0;
    bit prev = 1'b0, done = 1'b0;
    for (int c = 0; c < 7000 && !done; c++) begin
      if (buzzer && !prev) beeps++;
      if (buzzer) run++;
      if (!buzzer && prev) begin
        if (run != 200) bad_len++;
        run = 0;
      end
      prev = buzzer;
      if (state == S_IDLE) done = 1'b1;
      else cyc(1'b0);
    end
    check_int({name, "_beeps"}, beeps, exp_beeps);
    check_int({name, "_bad_len"}, bad_len, 0);
    check_int({name, "_idle"}, int'(done), 1);
  endtask
`endif

  initial begin
    int highs, not_idle;

    vecs[0]  = mk("t_alarm",        1, 0, 0, 0, S_RING,   1, 1, 2'd3);
    vecs[1]  = mk("t_ring_hold",    0, 0, 0, 0, S_RING,   1, 1, 2'd3);
    vecs[2]  = mk("t_snz_press",    0, 0, 1, 0, S_SNOOZE, 0, 0, 2'd2);
    vecs[3]  = mk("t_snz_held",     0, 0, 1, 0, S_SNOOZE, 0, 0, 2'd2);
    vecs[4]  = mk("t_snz_release",  0, 0, 0, 0, S_SNOOZE, 0, 0, 2'd2);
    vecs[5]  = mk("t_alarm_in_snz", 1, 0, 0, 0, S_RING,   1, 1, 2'd2);
    vecs[6]  = mk("t_snz2",         0, 0, 1, 0, S_SNOOZE, 0, 0, 2'd1);
    vecs[7]  = mk("t_snz2_release", 0, 0, 0, 0, S_SNOOZE, 0, 0, 2'd1);
    vecs[8]  = mk("t_stop_in_snz",  0, 0, 0, 1, S_IDLE,   0, 0, 2'd1);
    vecs[9]  = mk("t_stop_release", 0, 0, 0, 0, S_IDLE,   0, 0, 2'd1);
    vecs[10] = mk("t_alarm_reload", 1, 0, 0, 0, S_RING,   1, 1, 2'd3);
    vecs[11] = mk("t_stop_and_snz", 0, 0, 1, 1, S_IDLE,   0, 0, 2'd3);
    vecs[12] = mk("t_both_release", 0, 0, 0, 0, S_IDLE,   0, 0, 2'd3);
    vecs[13] = mk("t_stop_in_idle", 0, 0, 0, 1, S_IDLE,   0, 0, 2'd3);
    vecs[14] = mk("t_alarm_stp_hd", 1, 0, 0, 1, S_RING,   1, 1, 2'd3);
    vecs[15] = mk("t_stp_held",     0, 0, 0, 1, S_RING,   1, 1, 2'd3);
    vecs[16] = mk("t_stp_release",  0, 0, 0, 0, S_RING,   1, 1, 2'd3);
    vecs[17] = mk("t_stp_press",    0, 0, 0, 1, S_IDLE,   0, 0, 2'd3);
    vecs[18] = mk("t_stp_release2", 0, 0, 0, 0, S_IDLE,   0, 0, 2'd3);
    vecs[19] = mk("t_alarm_chime",  1, 1, 0, 0, S_RING,   1, 1, 2'd3);

    cr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out("reset", S_IDLE, 1'b0, 1'b0, 2'd0, 1'b1);
      cyc(1'b1);
    end
    cr = 1'b0;

    hrs = 5'd15;
    for (int i = 0; i < NV; i++) begin
      alarm = vecs[i].alarm; chime = vecs[i].chime;
      snz = vecs[i].snz; stp = vecs[i].stp;
      expect_out(vecs[i].name, vecs[i].st, vecs[i].bz, vecs[i].led, vecs[i].sl, 1'b1);
      cyc(1'b1);
    end
    alarm = 1'b0; chime = 1'b0;

    // Alarm and chime together: ring wins and no chime follows the stop.
    stp = 1'b1;
    expect_out("d_stop", S_IDLE, 1'b0, 1'b0, 2'd3, 1'b1);
    cyc(1'b1);
    stp = 1'b0;
    count_highs(1200, highs, not_idle);
    check_int("d_no_beeps", highs, 0);

    // Ring pattern and timeout.
    do_reset();
    alarm = 1'b1;
    expect_out("a_entry", S_RING, 1'b1, 1'b1, 2'd3, 1'b1); cyc(1'b1);
    alarm = 1'b0;
    idle(248);
    expect_out("a_249", S_RING, 1'b1, 1'b1, 2'd3, 1'b1); cyc(1'b1);
    expect_out("a_250", S_RING, 1'b0, 1'b1, 2'd3, 1'b1); cyc(1'b1);
    idle(248);
    expect_out("a_499", S_RING, 1'b0, 1'b1, 2'd3, 1'b1); cyc(1'b1);
    expect_out("a_500", S_RING, 1'b1, 1'b1, 2'd3, 1'b1); cyc(1'b1);
    pulse_ticks(9);
    expect_out("a_tick9", S_RING, 1'b0, 1'b1, 2'd3, 1'b0); cyc(1'b1);
    tick = 1'b1;
    expect_out("a_tick10", S_IDLE, 1'b0, 1'b0, 2'd3, 1'b1); cyc(1'b1);
    tick = 1'b0;

    // Three snoozes, then the fourth press acts as a stop.
    do_reset();
    alarm = 1'b1;
    expect_out("b_entry", S_RING, 1'b1, 1'b1, 2'd3, 1'b1); cyc(1'b1);
    alarm = 1'b0;
    for (int s = 0; s < 3; s++) begin
      snz = 1'b1;
      expect_out("b_snooze", S_SNOOZE, 1'b0, 1'b0, 2'(2 - s), 1'b1); cyc(1'b1);
      snz = 1'b0;
      pulse_ticks(59);
      expect_out("b_wait59", S_SNOOZE, 1'b0, 1'b0, 2'(2 - s), 1'b1); cyc(1'b1);
      tick = 1'b1;
      expect_out("b_back", S_RING, 1'b1, 1'b1, 2'(2 - s), 1'b1); cyc(1'b1);
      tick = 1'b0;
    end
    snz = 1'b1;
    expect_out("b_fourth", S_IDLE, 1'b0, 1'b0, 2'd0, 1'b1); cyc(1'b1);
    snz = 1'b0;

    // Reset in the middle of a snooze, then an immediate alarm.
    do_reset();
    alarm = 1'b1;
    expect_out("e_entry", S_RING, 1'b1, 1'b1, 2'd3, 1'b1); cyc(1'b1);
    alarm = 1'b0; snz = 1'b1;
    expect_out("e_snooze", S_SNOOZE, 1'b0, 1'b0, 2'd2, 1'b1); cyc(1'b1);
    snz = 1'b0;
    pulse_ticks(5);
    cr = 1'b1;
    expect_out("e_reset", S_IDLE, 1'b0, 1'b0, 2'd0, 1'b1); cyc(1'b1);
    cr = 1'b0; alarm = 1'b1;
    expect_out("e_after", S_RING, 1'b1, 1'b1, 2'd3, 1'b1); cyc(1'b1);
    alarm = 1'b0;

`ifdef BUZZER_CHIME_EN
    begin
      int beeps;
      bit prev;
      do_reset();
      hrs = 5'd15; chime = 1'b1;
      expect_out("c15_entry", S_CHIME, 1'b1, 1'b0, 2'd0, 1'b1); cyc(1'b1);
      chime = 1'b0;
      watch_chime("c15", 3);
      hrs = 5'd0; chime = 1'b1;
      expect_out("c0_entry", S_CHIME, 1'b1, 1'b0, 2'd0, 1'b1); cyc(1'b1);
      chime = 1'b0;
      watch_chime("c0", 12);
      hrs = 5'd15; chime = 1'b1;
      expect_out("c_entry", S_CHIME, 1'b1, 1'b0, 2'd0, 1'b1); cyc(1'b1);
      chime = 1'b0;
      beeps = 1; prev = 1'b1;
      for (int c = 0; c < 1500 && beeps < 2; c++) begin
        cyc(1'b0);
        if (buzzer && !prev) beeps++;
        prev = buzzer;
      end
      check_int("c_beep2_reached", beeps, 2);
      alarm = 1'b1;
      expect_out("c_abort", S_RING, 1'b1, 1'b1, 2'd3, 1'b1); cyc(1'b1);
      alarm = 1'b0;
    end
`else
    do_reset();
    hrs = 5'd15; chime = 1'b1;
    expect_out("nc_chime", S_IDLE, 1'b0, 1'b0, 2'd0, 1'b1); cyc(1'b1);
    chime = 1'b0;
    count_highs(1500, highs, not_idle);
    check_int("nc_no_beeps", highs, 0);
    check_int("nc_stays_idle", not_idle, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
